// File: rtl/input_cond.sv
// input_cond: 2-flop synchroniser plus stable-count debounce for switches and buttons.
// Optional macro INPUT_COND_EDGE_EN builds the registered sw_chg / btn_rise / btn_fall strobes.
`default_nettype none

module input_cond #(
  parameter int SW_W      = 8,
  parameter int BTN_W     = 5,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [BTN_W-1:0] btn_in,
  output logic [SW_W-1:0]  sw_out,
  output logic [BTN_W-1:0] btn_out,
  output logic             sw_chg,
  output logic [BTN_W-1:0] btn_rise,
  output logic [BTN_W-1:0] btn_fall
);

  localparam int N  = SW_W + BTN_W;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

  logic [N-1:0]  s1_q, s1_d;
  logic [N-1:0]  s2_q, s2_d;
  logic [N-1:0]  deb_q, deb_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // Switches occupy the low bits, buttons the high bits of every per-bit vector.
  always_comb begin
    s1_d  = {btn_in, sw_in};
    s2_d  = s1_q;
    deb_d = deb_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == C_LAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_out  = deb_q[SW_W-1:0];
  assign btn_out = deb_q[N-1:SW_W];

`ifdef INPUT_COND_EDGE_EN
  logic [N-1:0]     upd;
  logic             sw_chg_q, sw_chg_d;
  logic [BTN_W-1:0] btn_rise_q, btn_rise_d;
  logic [BTN_W-1:0] btn_fall_q, btn_fall_d;

  // Strobes register on the same edge as deb_q so they line up with the new level.
  always_comb begin
    upd        = deb_d ^ deb_q;
    sw_chg_d   = |upd[SW_W-1:0];
    btn_rise_d = upd[N-1:SW_W] & deb_d[N-1:SW_W];
    btn_fall_d = upd[N-1:SW_W] & ~deb_d[N-1:SW_W];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_chg_q   <= 1'b0;
      btn_rise_q <= '0;
      btn_fall_q <= '0;
    end else begin
      sw_chg_q   <= sw_chg_d;
      btn_rise_q <= btn_rise_d;
      btn_fall_q <= btn_fall_d;
    end
  end

  assign sw_chg   = sw_chg_q;
  assign btn_rise = btn_rise_q;
  assign btn_fall = btn_fall_q;
`else
  assign sw_chg   = 1'b0;
  assign btn_rise = '0;
  assign btn_fall = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_cond.sv
// tb_input_cond: randomized and directed stimulus against a sliding-window debounce model.
`default_nettype none

module tb_input_cond;

  localparam int SW_W  = 8;
  localparam int BTN_W = 5;
  localparam int DB    = 4;
  localparam int N     = SW_W + BTN_W;
`ifdef INPUT_COND_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [SW_W-1:0]  sw_in;
  logic [BTN_W-1:0] btn_in;
  logic [SW_W-1:0]  sw_out;
  logic [BTN_W-1:0] btn_out;
  logic             sw_chg;
  logic [BTN_W-1:0] btn_rise;
  logic [BTN_W-1:0] btn_fall;

  int checks = 0;
  int errors = 0;

  input_cond #(.SW_W(SW_W), .BTN_W(BTN_W), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .btn_in(btn_in),
    .sw_out(sw_out), .btn_out(btn_out), .sw_chg(sw_chg),
    .btn_rise(btn_rise), .btn_fall(btn_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: raw history gives the synchronised sample; a bit flips once its last DB
  // synchronised samples all disagree with the current debounced level.
  logic [N-1:0]     raw_h0, raw_h1, s2_seen, flip, m_d;
  logic [N-1:0]     win [DB];
  logic             m_chg;
  logic [BTN_W-1:0] m_rise, m_fall;
  bit               valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      raw_h0 = '0; raw_h1 = '0; m_d = '0;
      for (int j = 0; j < DB; j++) win[j] = '0;
      m_chg = 1'b0; m_rise = '0; m_fall = '0;
      valid = 1'b1;
    end else begin
      s2_seen = raw_h1;
      raw_h1  = raw_h0;
      raw_h0  = {btn_in, sw_in};
      for (int j = DB - 1; j > 0; j--) win[j] = win[j-1];
      win[0] = s2_seen;
      flip = '0;
      for (int b = 0; b < N; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (win[j][b] == m_d[b]) all_diff = 1'b0;
        flip[b] = all_diff;
      end
      m_d    = m_d ^ flip;
      m_chg  = |flip[SW_W-1:0];
      m_rise = flip[N-1:SW_W] & m_d[N-1:SW_W];
      m_fall = flip[N-1:SW_W] & ~m_d[N-1:SW_W];
    end
    #1;
    if (valid) begin
      check("model_sw_out",   32'(sw_out),   32'(m_d[SW_W-1:0]));
      check("model_btn_out",  32'(btn_out),  32'(m_d[N-1:SW_W]));
      check("model_sw_chg",   32'(sw_chg),   32'(m_chg & EDGE_EN));
      check("model_btn_rise", 32'(btn_rise), 32'(m_rise & {BTN_W{EDGE_EN}}));
      check("model_btn_fall", 32'(btn_fall), 32'(m_fall & {BTN_W{EDGE_EN}}));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; sw_in = 8'hFF; btn_in = 5'h1F;

    // Reset held with all inputs high
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_sw_out",  32'(sw_out),  32'h0);
      check("rst_btn_out", 32'(btn_out), 32'h0);
      check("rst_strobes", 32'({sw_chg, btn_rise, btn_fall}), 32'h0);
    end
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("rel_sw_out",   32'(sw_out),   (k >= 6) ? 32'hFF : 32'h0);
      check("rel_btn_out",  32'(btn_out),  (k >= 6) ? 32'h1F : 32'h0);
      check("rel_sw_chg",   32'(sw_chg),   32'((k == 6) & EDGE_EN));
      check("rel_btn_rise", 32'(btn_rise), (k == 6 && EDGE_EN) ? 32'h1F : 32'h0);
    end

    // Clean step 00 -> 05
    sw_in = 8'h00; btn_in = 5'h00;
    edges(10);
    check("idle_sw_out", 32'(sw_out), 32'h00);
    sw_in = 8'h05;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("step_sw_out", 32'(sw_out), (k >= 6) ? 32'h05 : 32'h00);
      check("step_sw_chg", 32'(sw_chg), 32'((k == 6) & EDGE_EN));
    end

    // Button glitch of 3 cycles is rejected
    btn_in = 5'b00100;
    edges(3);
    btn_in = 5'b00000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("glitch_btn_out",  32'(btn_out),  32'h0);
      check("glitch_btn_rise", 32'(btn_rise), 32'h0);
    end
    btn_in = 5'b00100;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("held_btn_out",  32'(btn_out),  (k >= 6) ? 32'h04 : 32'h00);
      check("held_btn_rise", 32'(btn_rise), (k == 6 && EDGE_EN) ? 32'h04 : 32'h00);
    end

    // Release edge on bit 0
    btn_in = 5'b00001;
    edges(10);
    btn_in = 5'b00000;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("rel0_btn_out",  32'(btn_out[0]), 32'(k < 6));
      check("rel0_btn_fall", 32'(btn_fall),   (k == 6 && EDGE_EN) ? 32'h01 : 32'h00);
    end

    // Reset one cycle in the middle of a count
    sw_in = 8'h85;
    edges(3);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_sw_out", 32'(sw_out), 32'h00);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("midrst_sw7", 32'(sw_out[7]), 32'(k == 6));
    end
    check("midrst_final", 32'(sw_out), 32'h85);

    // Bit toggling every cycle never reaches the output
    for (int k = 0; k < 20; k++) begin
      sw_in[3] = ~sw_in[3];
      @(negedge clk);
      check("toggle_sw_out", 32'(sw_out), 32'h85);
    end

    // Random phase: runs of held values, occasional glitches and resets
    for (int k = 0; k < 600; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8)       sw_in  = 8'($urandom);
      else if (r < 14) btn_in = 5'($urandom);
      else if (r < 22) sw_in[$urandom_range(0, SW_W-1)] ^= 1'b1;
      else if (r < 30) btn_in[$urandom_range(0, BTN_W-1)] ^= 1'b1;
      rst = ($urandom_range(0, 79) != 0);
      @(negedge clk);
    end
    rst = 1'b1;
    edges(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_cond.md
# input_cond

Input conditioning stage placed directly upstream of the switch/button consumers on the NVBoard example top (e.g. the priority-encoder LED block). It synchronises raw `sw`/`btn` board inputs into `clk`, debounces every bit with a stable-count filter, and emits clean levels plus one-cycle change strobes. Downstream logic then sees glitch-free, clock-aligned inputs only.

## Interface
- `SW_W`, 8, number of switch bits
- `BTN_W`, 5, number of button bits
- `DB_CYCLES`, 4, consecutive cycles a synchronised bit must differ from its debounced state before the state flips (legal range 1..65535)

- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-low (sampled on `clk` rising edge; 0 = reset)
- `sw_in`  in  SW_W  raw asynchronous switch levels
- `btn_in`  in  BTN_W  raw asynchronous button levels
- `sw_out`  out  SW_W  debounced switch levels
- `btn_out`  out  BTN_W  debounced button levels
- `sw_chg`  out  1  one-cycle pulse: some `sw_out` bit changed this cycle
- `btn_rise`  out  BTN_W  one-cycle pulse per bit on debounced 0->1
- `btn_fall`  out  BTN_W  one-cycle pulse per bit on debounced 1->0

## Operation
- Per input bit (switches and buttons identically): 2-flop synchroniser `s1 -> s2`, debounced state `d`, counter `c` of width clog2(DB_CYCLES+1).
- Each edge, per bit:
  - `s2 == d`: `c <= 0`.
  - `s2 != d` and `c < DB_CYCLES-1`: `c <= c+1`.
  - `s2 != d` and `c == DB_CYCLES-1`: `d <= s2`, `c <= 0` (update event).
- Any cycle where `s2` returns to `d` clears `c`; glitches shorter than DB_CYCLES cycles at `s2` never reach `d`.
- `sw_out`/`btn_out` are the `d` registers directly.
- `sw_chg` registered: high in the cycle after any switch update event, coincident with the new `sw_out` value. Multiple bits updating on the same edge give a single one-cycle pulse.
- `btn_rise[i]` / `btn_fall[i]` registered, coincident with the new `btn_out[i]`; never both high for one bit.
- Bits are fully independent; simultaneous updates on different bits all take effect on the same edge.
- No combinational path from any input to any output.

## Timing
- Reset (`rst==0` at an edge): `s1`, `s2`, `d`, `c`, all outputs <= 0. Reset mid-debounce discards partial counts.
- Latency: input stable at new value before edge 1 -> `s1` after edge 1, `s2` after edge 2, `d`/`sw_out`/`btn_out` change after edge 2+DB_CYCLES (default: 6 cycles). Strobes high for exactly that one cycle.
- After reset release with an input held at 1: output rises 2+DB_CYCLES cycles later, with `sw_chg`/`btn_rise` pulse.
- Input toggling every cycle forever: output never changes.
- DB_CYCLES=1: a bit updates on the first edge `s2 != d` (latency 3).

## Configuration
- `INPUT_COND_EDGE_EN` defined: `sw_chg`, `btn_rise`, `btn_fall` generated as above.
- Not defined: those three outputs tied constant 0, their registers not built; `sw_out`/`btn_out` behaviour and latency unchanged.

## Test plan
- Reset: drive `rst=0` 3 cycles with `sw_in=8'hFF`, `btn_in=5'h1F` -> all outputs 0 throughout; release -> `sw_out=8'hFF`, `btn_out=5'h1F` exactly 6 cycles after release, `sw_chg` and `btn_rise=5'h1F` high that one cycle only.
- Clean step: `sw_in` 8'h00 -> 8'h05 -> `sw_out=8'h05` after 6 edges, single `sw_chg` pulse; no change on cycles 1-5.
- Glitch reject: `btn_in[2]` high for 3 cycles then low -> `btn_out` stays 0, no `btn_rise`; held 4+ cycles -> `btn_out[2]=1` and `btn_rise=5'b00100` for one cycle.
- Release edge: `btn_in[0]` 1 -> 0 held -> `btn_fall=5'b00001` one cycle, coincident with `btn_out[0]` falling.
- Reset mid-count: `sw_in[7]` rises, `rst=0` on cycle 4 for one cycle -> `sw_out[7]` still 0, then rises 6 cycles after release.
- Macro off: repeat clean step without `INPUT_COND_EDGE_EN` -> identical `sw_out` timing, `sw_chg`/`btn_rise`/`btn_fall` constant 0.
